// File: rtl/alarm_bank.sv
`default_nettype none
// ============================================================================
// Module      : alarm_bank
// Description : N_ALARM programmable BCD alarm channels compared against the
//               running time. Each channel runs its own IDLE/RING(/SNOOZE)
//               state machine with a ring auto-timeout. CS acknowledges and
//               SNZ snoozes all channels together (rising edges).
//               Optional feature macro: ALARM_BANK_SNOOZE_EN builds the
//               SNOOZE state, the snooze counters and the SNZ edge path.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_bank #(
  parameter int N_ALARM    = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int SEL_W      = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic               CP,
  input  logic               CR,
  input  logic               TICK,
  input  logic [7:0]         TIME_H,
  input  logic [7:0]         TIME_M,
  input  logic [7:0]         TIME_S,
  input  logic               PE,
  input  logic [SEL_W-1:0]   SEL,
  input  logic [7:0]         D_H,
  input  logic [7:0]         D_M,
  input  logic [7:0]         D_S,
  input  logic               EN_IN,
  input  logic               CS,
  input  logic               SNZ,
  output logic [7:0]         BFM_H,
  output logic [7:0]         BFM_M,
  output logic [7:0]         BFM_S,
  output logic [N_ALARM-1:0] ARMED,
  output logic [N_ALARM-1:0] RING,
  output logic               TC,
  output logic [SEL_W-1:0]   ACT_ID
);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_RING   = 2'd1;
  localparam logic [7:0] c_RING_LOAD = 8'(RING_SEC);
`ifdef ALARM_BANK_SNOOZE_EN
  localparam logic [1:0]  c_ST_SNOOZE = 2'd2;
  localparam logic [15:0] c_SNZ_LOAD  = 16'(SNOOZE_MIN * 60);
`else
  localparam int c_snooze_unused = SNOOZE_MIN;
`endif

  // A stored digit pair above 9 can never be a legal time, so it never matches.
  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  logic                     r_cs_q, r_cs_q2;
  logic                     w_cs_edge;
  logic                     w_snz_edge;
  logic                     w_wr_ok;
  logic [N_ALARM-1:0][7:0]  w_h_all, w_m_all, w_s_all;
  logic [N_ALARM-1:0]       w_ring;

  // CS is registered once; the edge acts one cycle after it is first sampled.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      r_cs_q  <= 1'b0;
      r_cs_q2 <= 1'b0;
    end else begin
      r_cs_q  <= CS;
      r_cs_q2 <= r_cs_q;
    end
  end
  assign w_cs_edge = r_cs_q & ~r_cs_q2;

`ifdef ALARM_BANK_SNOOZE_EN
  logic r_snz_q, r_snz_q2;
  // SNZ edge detect, same latency as CS.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      r_snz_q  <= 1'b0;
      r_snz_q2 <= 1'b0;
    end else begin
      r_snz_q  <= SNZ;
      r_snz_q2 <= r_snz_q;
    end
  end
  assign w_snz_edge = r_snz_q & ~r_snz_q2;
`else
  logic w_snz_unused;
  assign w_snz_unused = SNZ;
  assign w_snz_edge   = 1'b0;
`endif

  assign w_wr_ok = PE && (int'(SEL) < N_ALARM);

  for (genvar gi = 0; gi < N_ALARM; gi++) begin : g_ch
    logic [7:0] r_h, r_m, r_s;
    logic       r_en;
    logic [1:0] r_state, w_state_nxt;
    logic [7:0] r_ring_cnt, w_ring_nxt;
    logic       w_wr, w_match, w_ring_bit;
`ifdef ALARM_BANK_SNOOZE_EN
    logic [15:0] r_snz_cnt, w_snz_nxt;
`endif

    assign w_wr    = w_wr_ok && (int'(SEL) == gi);
    assign w_match = TICK && r_en && bcd_ok(r_h) && bcd_ok(r_m) && bcd_ok(r_s) &&
                     (TIME_H == r_h) && (TIME_M == r_m) && (TIME_S == r_s);

    // Alarm time and arm bit storage.
    always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
        r_h  <= 8'h00;
        r_m  <= 8'h00;
        r_s  <= 8'h00;
        r_en <= 1'b0;
      end else if (w_wr) begin
        r_h  <= D_H;
        r_m  <= D_M;
        r_s  <= D_S;
        r_en <= EN_IN;
      end
    end

    // State and counter registers.
    always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
        r_state    <= c_ST_IDLE;
        r_ring_cnt <= 8'd0;
`ifdef ALARM_BANK_SNOOZE_EN
        r_snz_cnt  <= 16'd0;
`endif
      end else begin
        r_state    <= w_state_nxt;
        r_ring_cnt <= w_ring_nxt;
`ifdef ALARM_BANK_SNOOZE_EN
        r_snz_cnt  <= w_snz_nxt;
`endif
      end
    end

    // Next state: write > CS edge > SNZ edge > timeout/match.
    always_comb begin
      w_state_nxt = r_state;
      w_ring_nxt  = r_ring_cnt;
`ifdef ALARM_BANK_SNOOZE_EN
      w_snz_nxt   = r_snz_cnt;
`endif
      if (w_wr) begin
        w_state_nxt = c_ST_IDLE;
        w_ring_nxt  = 8'd0;
`ifdef ALARM_BANK_SNOOZE_EN
        w_snz_nxt   = 16'd0;
`endif
      end else begin
        case (r_state)
          c_ST_IDLE: begin
            if (w_match && !w_cs_edge) begin
              w_state_nxt = c_ST_RING;
              w_ring_nxt  = c_RING_LOAD;
            end
          end
          c_ST_RING: begin
            if (w_cs_edge) begin
              w_state_nxt = c_ST_IDLE;
              w_ring_nxt  = 8'd0;
            end else if (w_snz_edge) begin
`ifdef ALARM_BANK_SNOOZE_EN
              w_state_nxt = c_ST_SNOOZE;
              w_ring_nxt  = 8'd0;
              w_snz_nxt   = c_SNZ_LOAD;
`endif
            end else if (TICK) begin
              if (r_ring_cnt <= 8'd1) begin
                w_state_nxt = c_ST_IDLE;
                w_ring_nxt  = 8'd0;
              end else begin
                w_ring_nxt  = r_ring_cnt - 8'd1;
              end
            end
          end
`ifdef ALARM_BANK_SNOOZE_EN
          c_ST_SNOOZE: begin
            if (w_cs_edge) begin
              w_state_nxt = c_ST_IDLE;
              w_snz_nxt   = 16'd0;
            end else if (TICK) begin
              if ((r_snz_cnt <= 16'd1) || w_match) begin
                w_state_nxt = c_ST_RING;
                w_ring_nxt  = c_RING_LOAD;
                w_snz_nxt   = 16'd0;
              end else begin
                w_snz_nxt   = r_snz_cnt - 16'd1;
              end
            end
          end
`endif
          default: begin
            w_state_nxt = c_ST_IDLE;
            w_ring_nxt  = 8'd0;
          end
        endcase
      end
    end

    // Output decode: the ringing flag is a pure function of the state register.
    always_comb begin
      w_ring_bit = (r_state == c_ST_RING);
    end

    assign w_ring[gi]  = w_ring_bit;
    assign w_h_all[gi] = r_h;
    assign w_m_all[gi] = r_m;
    assign w_s_all[gi] = r_s;
    assign ARMED[gi]   = r_en;
  end

  assign RING = w_ring;
  assign TC   = |w_ring;

  // Lowest-index ringing channel wins; zero when nothing rings.
  always_comb begin
    ACT_ID = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (w_ring[i]) ACT_ID = SEL_W'(i);
    end
  end

  // Combinational readback of the selected channel; out-of-range reads zero.
  always_comb begin
    BFM_H = 8'h00;
    BFM_M = 8'h00;
    BFM_S = 8'h00;
    if (int'(SEL) < N_ALARM) begin
      BFM_H = w_h_all[SEL];
      BFM_M = w_m_all[SEL];
      BFM_S = w_s_all[SEL];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alarm_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_bank
// Description : Self-checking bench for alarm_bank (4 channels, RING_SEC=3,
//               SNOOZE_MIN=1). Expectations follow ALARM_BANK_SNOOZE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       TICK = 1'b0;
  logic [7:0] TH = 8'h00, TM = 8'h00, TS = 8'h00;
  logic       PE = 1'b0;
  logic [1:0] SEL = 2'd0;
  logic [7:0] DH = 8'h00, DM = 8'h00, DS = 8'h00;
  logic       EN = 1'b0, CS = 1'b0, SNZ = 1'b0;
  wire  [7:0] BH, BM, BS;
  wire  [3:0] ARMED, RING;
  wire        TC;
  wire  [1:0] ACT_ID;

  always #5 clk = ~clk;

  alarm_bank #(.N_ALARM(4), .RING_SEC(3), .SNOOZE_MIN(1)) dut (
    .CP(clk), .CR(rst), .TICK(TICK),
    .TIME_H(TH), .TIME_M(TM), .TIME_S(TS),
    .PE(PE), .SEL(SEL), .D_H(DH), .D_M(DM), .D_S(DS), .EN_IN(EN),
    .CS(CS), .SNZ(SNZ),
    .BFM_H(BH), .BFM_M(BM), .BFM_S(BS),
    .ARMED(ARMED), .RING(RING), .TC(TC), .ACT_ID(ACT_ID)
  );

  typedef struct {
    bit         tick;
    logic [23:0] t;
    bit         pe;
    logic [1:0] sel;
    logic [23:0] d;
    bit         en;
    bit         cs;
    bit         snz;
    logic [3:0] ring;
    logic [1:0] act;
  } step_t;

  typedef struct {
    string      name;
    int         idx;
    logic [3:0] ring;
    logic [1:0] act;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef ALARM_BANK_SNOOZE_EN
  localparam bit SNZ_ON = 1'b1;
`else
  localparam bit SNZ_ON = 1'b0;
`endif

  function automatic step_t mk(bit tick, logic [23:0] t, bit pe, logic [1:0] sel,
                               logic [23:0] d, bit en, bit cs, bit snz,
                               logic [3:0] ring, logic [1:0] act);
    step_t s;
    s.tick = tick; s.t = t; s.pe = pe; s.sel = sel; s.d = d; s.en = en;
    s.cs = cs; s.snz = snz; s.ring = ring; s.act = act;
    return s;
  endfunction

  function automatic step_t tk(logic [23:0] t, logic [3:0] ring, logic [1:0] act);
    return mk(1'b1, t, 1'b0, 2'd0, 24'h0, 1'b0, 1'b0, 1'b0, ring, act);
  endfunction

  function automatic step_t wr(logic [1:0] sel, logic [23:0] d, bit en,
                               logic [3:0] ring, logic [1:0] act);
    return mk(1'b0, 24'h0, 1'b1, sel, d, en, 1'b0, 1'b0, ring, act);
  endfunction

  function automatic step_t ctl(bit cs, bit snz, logic [3:0] ring, logic [1:0] act);
    return mk(1'b0, 24'h0, 1'b0, 2'd0, 24'h0, 1'b0, cs, snz, ring, act);
  endfunction

  function automatic void sb_push(string name, int idx, logic [3:0] ring, logic [1:0] act);
    exp_t e;
    e.name = name; e.idx = idx; e.ring = ring; e.act = act;
    sb.push_back(e);
  endfunction

  // Drive one cycle of stimulus starting at a negedge; returns at the next negedge.
  task automatic drive_cycle(input step_t s);
    TICK = s.tick; {TH, TM, TS} = s.t;
    PE = s.pe; SEL = s.sel; {DH, DM, DS} = s.d; EN = s.en;
    CS = s.cs; SNZ = s.snz;
    @(negedge clk);
    TICK = 1'b0; PE = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    @(negedge clk);
    sb_push("reset", 0, 4'b0000, 2'd0);
    e = sb.pop_front();
    n_checks++;
    if (RING !== e.ring || ACT_ID !== e.act || TC !== 1'b0 || ARMED !== 4'b0000) begin
      n_errors++;
      $display("FAIL %s: RING=%b ACT_ID=%0d TC=%b ARMED=%b, expected all zero",
               e.name, RING, ACT_ID, TC, ARMED);
    end
    for (int s = 0; s < 4; s++) begin
      SEL = 2'(s); #1;
      n_checks++;
      if ({BH, BM, BS} !== 24'h000000) begin
        n_errors++;
        $display("FAIL reset_bfm[%0d]: BFM=%h, expected 000000", s, {BH, BM, BS});
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_match;
    step_t st[$];
    exp_t  e;
    st.push_back(wr(2'd2, 24'h073000, 1'b1, 4'b0000, 2'd0));
    st.push_back(tk(24'h072959, 4'b0000, 2'd0));
    st.push_back(tk(24'h073000, 4'b0100, 2'd2));
    st.push_back(ctl(1'b1, 1'b0, 4'b0100, 2'd2));
    st.push_back(ctl(1'b0, 1'b0, 4'b0000, 2'd0));
    for (int i = 0; i < st.size(); i++) begin
      sb_push("single_match", i, st[i].ring, st[i].act);
      drive_cycle(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (RING !== e.ring || ACT_ID !== e.act || TC !== (|e.ring)) begin
        n_errors++;
        $display("FAIL %s[%0d]: RING=%b ACT_ID=%0d TC=%b, expected RING=%b ACT_ID=%0d TC=%b",
                 e.name, e.idx, RING, ACT_ID, TC, e.ring, e.act, |e.ring);
      end
    end
    SEL = 2'd2; #1;
    n_checks++;
    if ({BH, BM, BS} !== 24'h073000 || ARMED !== 4'b0100) begin
      n_errors++;
      $display("FAIL readback_ch2: BFM=%h ARMED=%b, expected 073000 0100", {BH, BM, BS}, ARMED);
    end
  endtask

  task automatic test_two_channels;
    step_t st[$];
    exp_t  e;
    st.push_back(wr(2'd0, 24'h120000, 1'b1, 4'b0000, 2'd0));
    st.push_back(wr(2'd3, 24'h120000, 1'b1, 4'b0000, 2'd0));
    st.push_back(tk(24'h115959, 4'b0000, 2'd0));
    st.push_back(tk(24'h120000, 4'b1001, 2'd0));
    st.push_back(ctl(1'b1, 1'b0, 4'b1001, 2'd0));
    st.push_back(ctl(1'b0, 1'b0, 4'b0000, 2'd0));
    for (int i = 0; i < st.size(); i++) begin
      sb_push("two_channels", i, st[i].ring, st[i].act);
      drive_cycle(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (RING !== e.ring || ACT_ID !== e.act || TC !== (|e.ring)) begin
        n_errors++;
        $display("FAIL %s[%0d]: RING=%b ACT_ID=%0d TC=%b, expected RING=%b ACT_ID=%0d TC=%b",
                 e.name, e.idx, RING, ACT_ID, TC, e.ring, e.act, |e.ring);
      end
    end
  endtask

  task automatic test_timeout;
    step_t st[$];
    exp_t  e;
    st.push_back(tk(24'h120000, 4'b1001, 2'd0));
    st.push_back(ctl(1'b0, 1'b0, 4'b1001, 2'd0));
    st.push_back(tk(24'h120001, 4'b1001, 2'd0));
    st.push_back(ctl(1'b0, 1'b0, 4'b1001, 2'd0));
    st.push_back(tk(24'h120002, 4'b1001, 2'd0));
    st.push_back(tk(24'h120003, 4'b0000, 2'd0));
    st.push_back(tk(24'h120004, 4'b0000, 2'd0));
    for (int i = 0; i < st.size(); i++) begin
      sb_push("timeout", i, st[i].ring, st[i].act);
      drive_cycle(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (RING !== e.ring || ACT_ID !== e.act || TC !== (|e.ring)) begin
        n_errors++;
        $display("FAIL %s[%0d]: RING=%b ACT_ID=%0d TC=%b, expected RING=%b ACT_ID=%0d TC=%b",
                 e.name, e.idx, RING, ACT_ID, TC, e.ring, e.act, |e.ring);
      end
    end
  endtask

  task automatic test_snooze;
    step_t      st[$];
    exp_t       e;
    logic [3:0] r;
    st.push_back(wr(2'd1, 24'h080000, 1'b1, 4'b0000, 2'd0));
    st.push_back(tk(24'h080000, 4'b0010, 2'd1));
    st.push_back(ctl(1'b0, 1'b1, 4'b0010, 2'd1));
    st.push_back(ctl(1'b0, 1'b0, SNZ_ON ? 4'b0000 : 4'b0010, SNZ_ON ? 2'd0 : 2'd1));
    for (int k = 1; k <= 63; k++) begin
      if (SNZ_ON) r = (k >= 60 && k < 63) ? 4'b0010 : 4'b0000;
      else        r = (k < 3) ? 4'b0010 : 4'b0000;
      st.push_back(tk(24'h090000, r, (r != 4'b0000) ? 2'd1 : 2'd0));
    end
    for (int i = 0; i < st.size(); i++) begin
      sb_push("snooze", i, st[i].ring, st[i].act);
      drive_cycle(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (RING !== e.ring || ACT_ID !== e.act || TC !== (|e.ring)) begin
        n_errors++;
        $display("FAIL %s[%0d]: RING=%b ACT_ID=%0d TC=%b, expected RING=%b ACT_ID=%0d TC=%b",
                 e.name, e.idx, RING, ACT_ID, TC, e.ring, e.act, |e.ring);
      end
    end
  endtask

  task automatic test_cs_snz_same;
    step_t st[$];
    exp_t  e;
    st.push_back(tk(24'h080000, 4'b0010, 2'd1));
    st.push_back(ctl(1'b1, 1'b1, 4'b0010, 2'd1));
    st.push_back(ctl(1'b0, 1'b0, 4'b0000, 2'd0));
    for (int k = 1; k <= 63; k++) st.push_back(tk(24'h090000, 4'b0000, 2'd0));
    for (int i = 0; i < st.size(); i++) begin
      sb_push("cs_snz_same", i, st[i].ring, st[i].act);
      drive_cycle(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (RING !== e.ring || ACT_ID !== e.act || TC !== (|e.ring)) begin
        n_errors++;
        $display("FAIL %s[%0d]: RING=%b ACT_ID=%0d TC=%b, expected RING=%b ACT_ID=%0d TC=%b",
                 e.name, e.idx, RING, ACT_ID, TC, e.ring, e.act, |e.ring);
      end
    end
  endtask

  task automatic test_disarm;
    step_t st[$];
    exp_t  e;
    st.push_back(tk(24'h080000, 4'b0010, 2'd1));
    st.push_back(wr(2'd1, 24'h080000, 1'b0, 4'b0000, 2'd0));
    st.push_back(tk(24'h080000, 4'b0000, 2'd0));
    for (int i = 0; i < st.size(); i++) begin
      sb_push("disarm", i, st[i].ring, st[i].act);
      drive_cycle(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (RING !== e.ring || ACT_ID !== e.act || TC !== (|e.ring)) begin
        n_errors++;
        $display("FAIL %s[%0d]: RING=%b ACT_ID=%0d TC=%b, expected RING=%b ACT_ID=%0d TC=%b",
                 e.name, e.idx, RING, ACT_ID, TC, e.ring, e.act, |e.ring);
      end
    end
    n_checks++;
    if (ARMED !== 4'b1101) begin
      n_errors++;
      $display("FAIL disarm_armed: ARMED=%b, expected 1101", ARMED);
    end
  endtask

  task automatic test_invalid_bcd;
    step_t st[$];
    exp_t  e;
    st.push_back(wr(2'd1, 24'h0A0000, 1'b1, 4'b0000, 2'd0));
    st.push_back(tk(24'h0A0000, 4'b0000, 2'd0));
    st.push_back(tk(24'h0A0000, 4'b0000, 2'd0));
    for (int i = 0; i < st.size(); i++) begin
      sb_push("invalid_bcd", i, st[i].ring, st[i].act);
      drive_cycle(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (RING !== e.ring || ACT_ID !== e.act || TC !== (|e.ring)) begin
        n_errors++;
        $display("FAIL %s[%0d]: RING=%b ACT_ID=%0d TC=%b, expected RING=%b ACT_ID=%0d TC=%b",
                 e.name, e.idx, RING, ACT_ID, TC, e.ring, e.act, |e.ring);
      end
    end
    SEL = 2'd1; #1;
    n_checks++;
    if ({BH, BM, BS} !== 24'h0A0000 || ARMED !== 4'b1111) begin
      n_errors++;
      $display("FAIL invalid_readback: BFM=%h ARMED=%b, expected 0A0000 1111", {BH, BM, BS}, ARMED);
    end
  endtask

  task automatic test_async_reset;
    step_t st[$];
    exp_t  e;
    st.push_back(tk(24'h120000, 4'b1001, 2'd0));
    for (int i = 0; i < st.size(); i++) begin
      sb_push("pre_reset", i, st[i].ring, st[i].act);
      drive_cycle(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (RING !== e.ring || ACT_ID !== e.act || TC !== (|e.ring)) begin
        n_errors++;
        $display("FAIL %s[%0d]: RING=%b ACT_ID=%0d TC=%b, expected RING=%b ACT_ID=%0d TC=%b",
                 e.name, e.idx, RING, ACT_ID, TC, e.ring, e.act, |e.ring);
      end
    end
    // Assert the clear between clock edges: outputs must drop without a CP edge.
    @(posedge clk); #2;
    rst = 1'b1;
    sb_push("cr_async", 0, 4'b0000, 2'd0);
    #1;
    e = sb.pop_front();
    n_checks++;
    if (RING !== e.ring || ACT_ID !== e.act || TC !== 1'b0 || ARMED !== 4'b0000) begin
      n_errors++;
      $display("FAIL %s: RING=%b ACT_ID=%0d TC=%b ARMED=%b, expected all zero",
               e.name, RING, ACT_ID, TC, ARMED);
    end
    for (int s = 0; s < 4; s++) begin
      SEL = 2'(s); #1;
      n_checks++;
      if ({BH, BM, BS} !== 24'h000000) begin
        n_errors++;
        $display("FAIL cr_bfm[%0d]: BFM=%h, expected 000000", s, {BH, BM, BS});
      end
    end
    @(negedge clk);
    rst = 1'b0;
    st.delete();
    st.push_back(tk(24'h000000, 4'b0000, 2'd0));
    st.push_back(tk(24'h000001, 4'b0000, 2'd0));
    for (int i = 0; i < st.size(); i++) begin
      sb_push("post_reset_midnight", i, st[i].ring, st[i].act);
      drive_cycle(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (RING !== e.ring || ACT_ID !== e.act || TC !== (|e.ring)) begin
        n_errors++;
        $display("FAIL %s[%0d]: RING=%b ACT_ID=%0d TC=%b, expected RING=%b ACT_ID=%0d TC=%b",
                 e.name, e.idx, RING, ACT_ID, TC, e.ring, e.act, |e.ring);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single_match;
    test_two_channels;
    test_timeout;
    test_snooze;
    test_cs_snz_same;
    test_disarm;
    test_invalid_bcd;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, time=%0t, expected completion before 2000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
